interrupt_request_resolver: RTL and testbench

INTERRUPT_REQUEST_RESOLVER -- requirements
Module: interrupt_request_resolver

---
 rtl/interrupt_request_resolver_pkg.sv | 36 +++
 rtl/interrupt_request_resolver_priority_resolver.sv | 36 +++
 rtl/interrupt_request_resolver.sv | 74 +++++++
 tb/tb_interrupt_request_resolver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/interrupt_request_resolver_pkg.sv
// Shared types and helpers for the interrupt request register and its priority logic.
// Priority vectors are indexed by rank, where bit 0 holds the highest-priority level.
package interrupt_request_resolver_pkg;

  localparam int unsigned IRQ_LINES = 8;

  // One-hot-or-zero level vector (also used for plain request vectors).
  typedef logic [IRQ_LINES-1:0] level_t;

  typedef enum logic {
    EDGE_MODE  = 1'b0,
    LEVEL_MODE = 1'b1
  } trigger_mode_t;

  // Reorder a level-indexed vector into a rank-indexed one.
  // Rank 0 is level (rotate+1) mod 8.
  function automatic level_t rotate_to_priority(input level_t vec, input logic [2:0] rotate);
    level_t r;
    r = '0;
    for (int unsigned p = 0; p < IRQ_LINES; p++) begin
      r[p] = vec[3'(p + 32'(rotate) + 1)];
    end
    return r;
  endfunction

  // Inverse of rotate_to_priority: map a rank-indexed vector back to levels.
  function automatic level_t priority_to_level(input level_t vec, input logic [2:0] rotate);
    level_t r;
    r = '0;
    for (int unsigned p = 0; p < IRQ_LINES; p++) begin
      r[3'(p + 32'(rotate) + 1)] = vec[p];
    end
    return r;
  endfunction

endpackage

// File: rtl/interrupt_request_resolver_priority_resolver.sv
// Combinational rotating-priority arbiter: grants the best request that outranks the in-service level.
// Shared with the in-service register block.
module priority_resolver
  import interrupt_request_resolver_pkg::*;
(
  input  logic [IRQ_LINES-1:0] request,
  input  logic [IRQ_LINES-1:0] in_service,
  input  logic [2:0]           rotate,
  output logic [IRQ_LINES-1:0] grant
);

  level_t req_rank;
  level_t isr_rank;
  level_t grant_rank;
  logic   blocked;

  always_comb begin
    req_rank   = rotate_to_priority(request, rotate);
    isr_rank   = rotate_to_priority(in_service, rotate);
    grant_rank = '0;
    blocked    = 1'b0;
    // The in-service check comes first at each rank, so a request at the same level is refused.
    for (int unsigned p = 0; p < IRQ_LINES; p++) begin
      if (!blocked) begin
        if (isr_rank[p]) begin
          blocked = 1'b1;
        end else if (req_rank[p]) begin
          grant_rank[p] = 1'b1;
          blocked       = 1'b1;
        end
      end
    end
    grant = priority_to_level(grant_rank, rotate);
  end

endmodule

// File: rtl/interrupt_request_resolver.sv
// Interrupt request register (IRR) supporting edge and level triggering.
// It also produces the combinational winning request for the control logic.
module interrupt_request_resolver
  import interrupt_request_resolver_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IRQ_LINES-1:0] interrupt_request_pin,
  input  logic                 level_or_edge_toriggered_config,
  input  logic                 ICW_1,
  input  logic                 freeze,
  input  logic [IRQ_LINES-1:0] clear_interrupt_request,
  input  logic [IRQ_LINES-1:0] interrupt_mask,
  input  logic [IRQ_LINES-1:0] highest_level_in_service,
  input  logic [2:0]           priority_rotate,
  output logic [IRQ_LINES-1:0] interrupt_request_register,
  output logic [IRQ_LINES-1:0] interrupt
);

  trigger_mode_t mode;
  level_t        irr;
  level_t        armed;
  level_t        irr_next;
  level_t        armed_next;
  level_t        capture;

  assign mode = trigger_mode_t'(level_or_edge_toriggered_config);

  always_comb begin
    irr_next   = irr;
    armed_next = armed;
    capture    = '0;
    for (int unsigned i = 0; i < IRQ_LINES; i++) begin
      capture[i] = (mode == EDGE_MODE) && !freeze && interrupt_request_pin[i] && armed[i];

      // A low pin always re-arms; a capture or an edge-mode clear consumes the arm.
      armed_next[i] = !interrupt_request_pin[i] ||
                      (armed[i] && !capture[i] &&
                       !(clear_interrupt_request[i] && mode == EDGE_MODE));

      if (clear_interrupt_request[i]) begin
        irr_next[i] = 1'b0;
      end else if (freeze) begin
        irr_next[i] = irr[i];
      end else if (mode == LEVEL_MODE) begin
        irr_next[i] = interrupt_request_pin[i];
      end else if (!interrupt_request_pin[i]) begin
        irr_next[i] = 1'b0;
      end else if (capture[i]) begin
        irr_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || ICW_1) begin
      irr   <= '0;
      armed <= '0;
    end else begin
      irr   <= irr_next;
      armed <= armed_next;
    end
  end

  priority_resolver u_priority_resolver (
    .request    (irr & ~interrupt_mask),
    .in_service (highest_level_in_service),
    .rotate     (priority_rotate),
    .grant      (interrupt)
  );

  assign interrupt_request_register = irr;

endmodule

// File: tb/tb_interrupt_request_resolver.sv
// Self-checking bench for interrupt_request_resolver: directed vector table plus randomized level-mode checks.
module tb_interrupt_request_resolver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pin;
  logic       lvl_cfg;
  logic       icw1;
  logic       freeze;
  logic [7:0] clr;
  logic [7:0] mask;
  logic [7:0] isr;
  logic [2:0] rot;
  logic [7:0] irr_out;
  logic [7:0] int_out;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [7:0] pin;
    logic       lvl;
    logic       icw;
    logic       frz;
    logic [7:0] clr;
    logic [7:0] mask;
    logic [7:0] isr;
    logic [2:0] rot;
    logic [7:0] e_irr;
    logic [7:0] e_int;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] e_irr;
    logic [7:0] e_int;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  interrupt_request_resolver dut (
    .clk                             (clk),
    .reset_n                         (reset_n),
    .interrupt_request_pin           (pin),
    .level_or_edge_toriggered_config (lvl_cfg),
    .ICW_1                           (icw1),
    .freeze                          (freeze),
    .clear_interrupt_request         (clr),
    .interrupt_mask                  (mask),
    .highest_level_in_service        (isr),
    .priority_rotate                 (rot),
    .interrupt_request_register      (irr_out),
    .interrupt                       (int_out)
  );

  // Walks the levels in priority order; stops at the in-service level.
  function automatic logic [7:0] model_int(input logic [7:0] req, input logic [7:0] in_svc,
                                           input logic [2:0] r);
    for (int k = 1; k <= 8; k++) begin
      int l;
      l = (int'(r) + k) % 8;
      if (in_svc[l]) return 8'h00;
      if (req[l]) return 8'(1 << l);
    end
    return 8'h00;
  endfunction

  function automatic void add(input string n, input logic rn, input logic [7:0] p, input logic l,
                              input logic ic, input logic fz, input logic [7:0] c,
                              input logic [7:0] m, input logic [7:0] s, input logic [2:0] r,
                              input logic [7:0] ei, input logic [7:0] en);
    vec_t v;
    v.name = n; v.rst_n = rn; v.pin = p; v.lvl = l; v.icw = ic; v.frz = fz; v.clr = c;
    v.mask = m; v.isr = s; v.rot = r; v.e_irr = ei; v.e_int = en;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset_n = v.rst_n; pin = v.pin; lvl_cfg = v.lvl; icw1 = v.icw; freeze = v.frz;
    clr = v.clr; mask = v.mask; isr = v.isr; rot = v.rot;
    sb.push_back('{v.name, v.e_irr, v.e_int});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if (irr_out !== e.e_irr) begin
      mismatched++;
      $display("FAIL %s irr: got %02h expected %02h", e.name, irr_out, e.e_irr);
    end
    compared++;
    if (int_out !== e.e_int) begin
      mismatched++;
      $display("FAIL %s interrupt: got %02h expected %02h", e.name, int_out, e.e_int);
    end
  endtask

  initial begin
    reset_n = 1'b0; pin = '0; lvl_cfg = 1'b0; icw1 = 1'b0; freeze = 1'b0;
    clr = '0; mask = '0; isr = '0; rot = 3'd7;

    //   name          rst pin   lvl icw frz clr    mask   isr    rot  irr    int
    add("reset",       0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("arm_low",     1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("edge_rise",   1, 8'h04, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h04, 8'h04);
    add("edge_clear",  1, 8'h04, 0, 0, 0, 8'h04, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("edge_held",   1, 8'h04, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("edge_relow",  1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("edge_rerise", 1, 8'h04, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h04, 8'h04);
    add("withdraw",    1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("frz_low",     1, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("frz_rise",    1, 8'h10, 0, 0, 1, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("frz_drop",    1, 8'h10, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h10, 8'h10);
    add("frz_clear",   1, 8'h10, 0, 0, 1, 8'h10, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("lvl_mask",    1, 8'h81, 1, 0, 0, 8'h00, 8'h01, 8'h00, 7, 8'h81, 8'h80);
    add("lvl_isr_hi",  1, 8'h81, 1, 0, 0, 8'h00, 8'h01, 8'h40, 7, 8'h81, 8'h00);
    add("lvl_isr_eq",  1, 8'h81, 1, 0, 0, 8'h00, 8'h01, 8'h80, 7, 8'h81, 8'h00);
    add("rot3",        1, 8'h09, 1, 0, 0, 8'h00, 8'h00, 8'h00, 3, 8'h09, 8'h01);
    add("rot7",        1, 8'h09, 1, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h09, 8'h01);
    add("rot0",        1, 8'h09, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h09, 8'h08);
    add("rot3_isr0",   1, 8'h09, 1, 0, 0, 8'h00, 8'h00, 8'h01, 3, 8'h09, 8'h00);
    add("rot3_isr3",   1, 8'h09, 1, 0, 0, 8'h00, 8'h00, 8'h08, 3, 8'h09, 8'h01);
    add("all_high",    1, 8'hFF, 1, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'hFF, 8'h01);
    add("icw1",        1, 8'hFF, 1, 1, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("icw1_edge1",  1, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("icw1_edge2",  1, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("lvl_reload",  1, 8'hFF, 1, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'hFF, 8'h01);
    add("mode_switch", 1, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'hFF, 8'h01);
    add("rst_frz",     0, 8'hFF, 0, 0, 1, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("rst_held",    1, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("rst_low",     1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);
    add("rst_rise",    1, 8'h01, 0, 0, 0, 8'h00, 8'h00, 8'h00, 7, 8'h01, 8'h01);
    add("icw1_frz",    1, 8'hFF, 0, 1, 1, 8'h00, 8'h00, 8'h00, 7, 8'h00, 8'h00);

    foreach (vecs[i]) apply(vecs[i]);

    // Level mode with random pins, mask, in-service level and rotation.
    for (int n = 0; n < 48; n++) begin
      vec_t v;
      logic [7:0] p;
      logic [7:0] m;
      logic [7:0] s;
      logic [2:0] r;
      p = 8'($urandom);
      m = 8'($urandom) & 8'($urandom);
      s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      r = 3'($urandom_range(0, 7));
      v.name = $sformatf("rand%0d", n);
      v.rst_n = 1'b1; v.pin = p; v.lvl = 1'b1; v.icw = 1'b0; v.frz = 1'b0; v.clr = 8'h00;
      v.mask = m; v.isr = s; v.rot = r; v.e_irr = p; v.e_int = model_int(p & ~m, s, r);
      apply(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
